// File: rtl/mem_stage_unit.sv
// MEM stage of the 16-bit WISC core: issues loads/stores over a valid/ready
// data-memory handshake, stalls upstream while waiting, registers results toward WB.
module mem_stage_unit #(
  parameter int TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        valid_in,
  input  logic        mem_to_reg_in,
  input  logic        reg_to_mem_in,
  input  logic        ret_future_in,
  input  logic [3:0]  reg_rd_in,
  input  logic [15:0] alu_result,
  input  logic [15:0] sw_data,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [15:0] dmem_addr,
  output logic [15:0] dmem_wdata,
  input  logic [15:0] dmem_rdata,
  input  logic        dmem_ready,
  output logic        stall,
  output logic        wb_valid,
  output logic [15:0] wb_data,
  output logic [3:0]  wb_rd,
  output logic        wb_mem_to_reg,
  output logic        ret_wb,
  output logic        mem_err
);

  typedef enum logic {IDLE, WAIT} state_t;

  // Instruction context held while the memory access is outstanding
  typedef struct packed {
    logic [3:0] rd;
    logic       ld;
    logic       ret;
  } pend_t;

  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  state_t     state, state_nxt;
  pend_t      pend;
  logic [7:0] wait_cnt;
  logic       mem_op, done, tmo;

  always_comb begin
    state_nxt = state;
    mem_op    = valid_in & (mem_to_reg_in | reg_to_mem_in);
    done      = 1'b0;
    tmo       = 1'b0;
    case (state)
      IDLE: if (mem_op) state_nxt = WAIT;
      WAIT: begin
        done = dmem_ready;
        // Counter holds completed no-ready cycles, so this is the TIMEOUT-th one
        tmo  = !dmem_ready && (wait_cnt == TMO_LAST);
        if (done || tmo) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign stall = (state == WAIT) && !(done || tmo);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= IDLE;
      pend          <= '0;
      wait_cnt      <= '0;
      dmem_req      <= 1'b0;
      dmem_we       <= 1'b0;
      dmem_addr     <= '0;
      dmem_wdata    <= '0;
      wb_valid      <= 1'b0;
      wb_data       <= '0;
      wb_rd         <= '0;
      wb_mem_to_reg <= 1'b0;
      ret_wb        <= 1'b0;
      mem_err       <= 1'b0;
    end else begin
      state         <= state_nxt;
      wb_valid      <= 1'b0;
      wb_data       <= '0;
      wb_rd         <= '0;
      wb_mem_to_reg <= 1'b0;
      ret_wb        <= 1'b0;
      case (state)
        IDLE: begin
          if (mem_op) begin
            dmem_req   <= 1'b1;
            dmem_we    <= reg_to_mem_in;
            dmem_addr  <= alu_result;
            dmem_wdata <= sw_data;
            // A store wins when both flags are set
            pend       <= '{rd: reg_rd_in, ld: mem_to_reg_in & ~reg_to_mem_in,
                            ret: ret_future_in};
            wait_cnt   <= '0;
          end else if (valid_in) begin
            wb_valid <= 1'b1;
            wb_data  <= alu_result;
            wb_rd    <= reg_rd_in;
            ret_wb   <= ret_future_in;
          end
        end
        WAIT: begin
          if (done) begin
            dmem_req      <= 1'b0;
            wb_valid      <= 1'b1;
            wb_data       <= pend.ld ? dmem_rdata : dmem_addr;
            wb_rd         <= pend.rd;
            wb_mem_to_reg <= pend.ld;
            ret_wb        <= pend.ret;
            wait_cnt      <= '0;
          end else if (tmo) begin
            dmem_req <= 1'b0;
            mem_err  <= 1'b1;
            wait_cnt <= '0;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage_unit.sv
// Bench for mem_stage_unit: directed vector table, reset corner cases, and
// random transactions against a transaction-level memory model.
module tb_mem_stage_unit;
  localparam int TMO = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        valid_in, mem_to_reg_in, reg_to_mem_in, ret_future_in;
  logic [3:0]  reg_rd_in;
  logic [15:0] alu_result, sw_data, dmem_rdata;
  logic        dmem_ready;
  logic        dmem_req, dmem_we, stall, wb_valid, wb_mem_to_reg, ret_wb, mem_err;
  logic [15:0] dmem_addr, dmem_wdata, wb_data;
  logic [3:0]  wb_rd;

  int   n_chk = 0, n_fail = 0;
  logic err_exp = 1'b0;
  logic [15:0] mem_m [logic [15:0]];

  mem_stage_unit #(.TIMEOUT(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .mem_to_reg_in(mem_to_reg_in),
    .reg_to_mem_in(reg_to_mem_in), .ret_future_in(ret_future_in), .reg_rd_in(reg_rd_in),
    .alu_result(alu_result), .sw_data(sw_data), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata),
    .dmem_ready(dmem_ready), .stall(stall), .wb_valid(wb_valid), .wb_data(wb_data),
    .wb_rd(wb_rd), .wb_mem_to_reg(wb_mem_to_reg), .ret_wb(ret_wb), .mem_err(mem_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        ld, st, ret;
    logic [3:0]  rd;
    logic [15:0] alu, sw;
    int          n;          // WAIT cycle carrying dmem_ready; 0 = never
    logic [15:0] rdata, exp_data;
    logic        exp_m2r;
  } vec_t;

  vec_t tbl[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One instruction from presentation to write-back; starts and ends #1 after an edge
  task automatic run_op(input logic ld, input logic st, input logic ret, input logic [3:0] rd,
                        input logic [15:0] alu, input logic [15:0] sw, input int n,
                        input logic [15:0] rdata, input logic [15:0] exp_data,
                        input logic exp_m2r);
    logic mem, tmo, held;
    int   cyc, stalls;
    mem = ld | st;
    tmo = mem && (n == 0 || n > TMO);
    valid_in = 1'b1; mem_to_reg_in = ld; reg_to_mem_in = st; ret_future_in = ret;
    reg_rd_in = rd; alu_result = alu; sw_data = sw;
    dmem_ready = 1'($urandom_range(0, 1)); dmem_rdata = 16'($urandom);
    #1 chk("idle_stall", 32'(stall), 0);
    @(posedge clk); #1;
    if (mem) begin
      chk("issue_req", 32'(dmem_req), 1);
      chk("issue_we", 32'(dmem_we), 32'(st));
      chk("issue_addr", 32'(dmem_addr), 32'(alu));
      chk("issue_wdata", 32'(dmem_wdata), 32'(sw));
      chk("issue_wbv", 32'(wb_valid), 0);
      // Junk presented while stalled must be ignored
      valid_in = 1'b1; mem_to_reg_in = 1'($urandom); reg_to_mem_in = 1'b1;
      alu_result = 16'($urandom); sw_data = 16'($urandom);
      cyc = tmo ? TMO : n;
      stalls = 0; held = 1'b1;
      for (int k = 1; k <= cyc; k++) begin
        dmem_ready = (k == n);
        dmem_rdata = (k == n) ? rdata : 16'($urandom);
        #1;
        if (stall) stalls++;
        if (dmem_req !== 1'b1 || dmem_we !== st || dmem_addr !== alu || dmem_wdata !== sw)
          held = 1'b0;
        @(posedge clk); #1;
      end
      dmem_ready = 1'b0;
      chk("wait_held", 32'(held), 1);
      chk("stall_cycles", 32'(stalls), 32'(cyc - 1));
      chk("done_req", 32'(dmem_req), 0);
      if (tmo) begin
        err_exp = 1'b1;
        chk("tmo_wbv", 32'(wb_valid), 0);
      end
    end
    if (!tmo) begin
      chk("wb_valid", 32'(wb_valid), 1);
      chk("wb_data", 32'(wb_data), 32'(exp_data));
      chk("wb_rd", 32'(wb_rd), 32'(rd));
      chk("wb_m2r", 32'(wb_mem_to_reg), 32'(exp_m2r));
      chk("ret_wb", 32'(ret_wb), 32'(ret));
      if (!mem) chk("alu_no_req", 32'(dmem_req), 0);
    end
    chk("mem_err", 32'(mem_err), 32'(err_exp));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [15:0] a, d, s, rv;
    logic ld, st;
    int op, n;

    tbl[0] = '{0, 0, 0, 4'd5,  16'h1234, 16'h0000, 0, 16'h0000, 16'h1234, 0};
    tbl[1] = '{0, 1, 0, 4'd2,  16'h00FE, 16'hA5A5, 1, 16'h0000, 16'h00FE, 0};
    tbl[2] = '{1, 0, 0, 4'd3,  16'h0040, 16'h0000, 3, 16'hBEEF, 16'hBEEF, 1};
    tbl[3] = '{1, 0, 1, 4'd7,  16'h0010, 16'h0000, 2, 16'h1111, 16'h1111, 1};
    tbl[4] = '{1, 1, 0, 4'd9,  16'h0020, 16'h7777, 2, 16'hDEAD, 16'h0020, 0};
    tbl[5] = '{0, 0, 1, 4'd15, 16'hFFFF, 16'h0000, 0, 16'h0000, 16'hFFFF, 0};
    tbl[6] = '{1, 0, 0, 4'd4,  16'h0044, 16'h0000, 0, 16'h0000, 16'h0000, 0};
    tbl[7] = '{1, 0, 0, 4'd6,  16'h0050, 16'h0000, TMO, 16'hCAFE, 16'hCAFE, 1};
    tbl[8] = '{0, 0, 0, 4'd1,  16'h0001, 16'h0000, 0, 16'h0000, 16'h0001, 0};

    rst_n = 1'b0; valid_in = 1'b0; mem_to_reg_in = 1'b0; reg_to_mem_in = 1'b0;
    ret_future_in = 1'b0; reg_rd_in = '0; alu_result = '0; sw_data = '0;
    dmem_rdata = '0; dmem_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req", 32'(dmem_req), 0);
    chk("rst_we", 32'(dmem_we), 0);
    chk("rst_addr", 32'(dmem_addr), 0);
    chk("rst_wdata", 32'(dmem_wdata), 0);
    chk("rst_wb", {wb_valid, wb_mem_to_reg, ret_wb, mem_err, wb_rd, wb_data}, 0);
    chk("rst_stall", 32'(stall), 0);
    rst_n = 1'b1;

    for (int i = 0; i < 9; i++)
      run_op(tbl[i].ld, tbl[i].st, tbl[i].ret, tbl[i].rd, tbl[i].alu, tbl[i].sw,
             tbl[i].n, tbl[i].rdata, tbl[i].exp_data, tbl[i].exp_m2r);

    // Reset in the middle of a WAIT abandons the access and clears the sticky error
    valid_in = 1'b1; mem_to_reg_in = 1'b1; reg_to_mem_in = 1'b0; alu_result = 16'h0080;
    @(posedge clk); #1;
    valid_in = 1'b0; dmem_ready = 1'b0;
    @(posedge clk); #1;
    chk("midwait_stall", 32'(stall), 1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("midrst_req", 32'(dmem_req), 0);
    chk("midrst_stall", 32'(stall), 0);
    chk("midrst_outs", {wb_valid, wb_mem_to_reg, ret_wb, mem_err, wb_rd, wb_data,
                        dmem_we, dmem_addr}, 0);
    rst_n = 1'b1; dmem_ready = 1'b1; dmem_rdata = 16'hFFFF;
    @(posedge clk); #1;
    chk("late_ready_wbv", 32'(wb_valid), 0);
    chk("late_ready_req", 32'(dmem_req), 0);
    dmem_ready = 1'b0;
    err_exp = 1'b0;

    // Random traffic against a sparse word memory
    for (int t = 0; t < 60; t++) begin
      op = $urandom_range(0, 3);
      ld = (op == 1) || (op == 3);
      st = (op == 2) || (op == 3);
      a  = {12'h000, 4'($urandom)};
      s  = 16'($urandom);
      n  = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, TMO + 2);
      rv = mem_m.exists(a) ? mem_m[a] : 16'($urandom);
      d  = st ? a : (ld ? rv : a);
      run_op(ld, st, 1'($urandom), 4'($urandom), a, s, n, rv, d, ld & ~st);
      if (st && n != 0 && n <= TMO) mem_m[a] = s;
    end

    valid_in = 1'b0;
    @(posedge clk); #1;
    chk("final_idle_wbv", 32'(wb_valid), 0);
    chk("final_idle_req", 32'(dmem_req), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
